// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// Common: shared types for the pipeline memory stage.
//   MemType - load/store access width and extension kind
//   Cond    - branch condition evaluated against ALU flags
//   Flags   - ALU status flags (zero, carry)
//   Signals - per-instruction bundle passed between pipeline stages
//   state_t - memory stage FSM encoding
//   cond_true() - evaluates a Cond against a Flags value
// ---------------------------------------------------------------------------
package Common;

   typedef enum logic [2:0] {
      MT_BYTE  = 3'd0,
      MT_HALF  = 3'd1,
      MT_WORD  = 3'd2,
      MT_BYTEU = 3'd3,
      MT_HALFU = 3'd4
   } MemType;

   typedef enum logic [2:0] {
      C_NEVER  = 3'd0,
      C_ALWAYS = 3'd1,
      C_EQ     = 3'd2,
      C_NE     = 3'd3,
      C_LT     = 3'd4,
      C_GE     = 3'd5
   } Cond;

   typedef struct packed {
      logic zero;
      logic carry;
   } Flags;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] reg2;
      logic        wback;
      logic [4:0]  wreg;
      logic [31:0] wdata;   // ALU result, or effective address for memory ops
      logic [31:0] branch;  // branch target
      Flags        flags;
      Cond         cond;
      logic        memr;
      logic        memw;
      MemType      memt;
   } Signals;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   function automatic logic cond_true(input Cond c, input Flags f);
      logic r;
      case (c)
         C_ALWAYS: r = 1'b1;
         C_EQ:     r = f.zero;
         C_NE:     r = ~f.zero;
         C_LT:     r = f.carry;
         C_GE:     r = ~f.carry;
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_align.sv
// ---------------------------------------------------------------------------
// mem_align: combinational data-bus alignment for the memory stage.
//   Request side : req_memt, req_addr_lo, reg2 -> be, wdata, misaligned
//                  (byte enables, lane-replicated store data, alignment fault)
//   Response side: rsp_memt, rsp_addr_lo, rdata -> load_data
//                  (lane select plus sign/zero extension)
// ---------------------------------------------------------------------------
module mem_align
   import Common::*;
(
   input  MemType      req_memt,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] reg2,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic        misaligned,
   input  MemType      rsp_memt,
   input  logic [1:0]  rsp_addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] load_data
);

   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[gi*8 +: 8];
   end

   always_comb begin
      be         = 4'b1111;
      wdata      = reg2;
      misaligned = 1'b0;
      case (req_memt)
         MT_BYTE, MT_BYTEU: begin
            be    = 4'b0001 << req_addr_lo;
            wdata = {4{reg2[7:0]}};
         end
         MT_HALF, MT_HALFU: begin
            be         = req_addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{reg2[15:0]}};
            misaligned = req_addr_lo[0];
         end
         default: begin
            // Word, and any unused encoding, is treated as a full word.
            misaligned = |req_addr_lo;
         end
      endcase
   end

   always_comb begin
      byte_sel = lane[rsp_addr_lo];
      half_sel = rsp_addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (rsp_memt)
         MT_BYTE:  load_data = {{24{byte_sel[7]}}, byte_sel};
         MT_BYTEU: load_data = {24'd0, byte_sel};
         MT_HALF:  load_data = {{16{half_sel[15]}}, half_sel};
         MT_HALFU: load_data = {16'd0, half_sel};
         default:  load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage: pipeline memory stage between ALU and writeback.
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   i_signals       - instruction from the ALU stage
//   o_signals       - instruction to writeback (wdata = load data or ALU result)
//   o_stall         - holds upstream while a memory access is in flight
//   o_redirect/o_target - registered taken-branch pulse and its target
//   o_fault         - one-cycle pulse on misaligned access or bus timeout
//   dmem_*          - request/ack data bus (req held until ack)
// Non-memory ops pass through in one cycle. Aligned loads/stores go
// Idle -> Access (bus request) -> Done (result presented) -> Idle.
// ---------------------------------------------------------------------------
module mem_stage
   import Common::*;
#(
   localparam int TIMEOUT_DEFAULT = 255,
   parameter  int TIMEOUT         = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  Signals      i_signals,
   output Signals      o_signals,
   output logic        o_stall,
   output logic        o_redirect,
   output logic [31:0] o_target,
   output logic        o_fault,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   Signals      cap_q, cap_d;        // memory op held for the whole access
   Signals      o_sig_q, o_sig_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        redirect_q, redirect_d;
   logic [31:0] target_q, target_d;
   logic        fault_q, fault_d;
   logic        stall;

   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic        al_misaligned;
   logic [31:0] al_load;
   logic        ack_v;
   logic        is_mem;

   mem_align u_align (
      .req_memt    (i_signals.memt),
      .req_addr_lo (i_signals.wdata[1:0]),
      .reg2        (i_signals.reg2),
      .be          (al_be),
      .wdata       (al_wdata),
      .misaligned  (al_misaligned),
      .rsp_memt    (cap_q.memt),
      .rsp_addr_lo (cap_q.wdata[1:0]),
      .rdata       (dmem_rdata),
      .load_data   (al_load)
   );

   // An ack with no outstanding request is stray and must not complete anything.
   assign ack_v  = dmem_ack & req_q;
   assign is_mem = i_signals.memr | i_signals.memw;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cap_d         = cap_q;
      o_sig_d       = o_sig_q;
      o_sig_d.valid = 1'b0;
      req_d         = req_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      be_d          = be_q;
      redirect_d    = 1'b0;
      target_d      = target_q;
      fault_d       = 1'b0;
      stall         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_signals.valid) begin
               redirect_d = cond_true(i_signals.cond, i_signals.flags);
               target_d   = i_signals.branch;
               if (is_mem && al_misaligned) begin
                  // Completes immediately as a non-writing op.
                  fault_d       = 1'b1;
                  o_sig_d       = i_signals;
                  o_sig_d.wback = 1'b0;
               end else if (is_mem) begin
                  stall   = 1'b1;
                  state_d = ST_ACCESS;
                  cnt_d   = '0;
                  cap_d   = i_signals;
                  req_d   = 1'b1;
                  we_d    = i_signals.memw;
                  addr_d  = {i_signals.wdata[31:2], 2'b00};
                  wdata_d = al_wdata;
                  be_d    = al_be;
               end else begin
                  o_sig_d = i_signals;
               end
            end
         end

         ST_ACCESS: begin
            stall = 1'b1;
            // Ack is checked first so it wins over a simultaneous timeout.
            if (ack_v) begin
               state_d = ST_DONE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               be_d    = 4'b0000;
               o_sig_d = cap_q;
               if (cap_q.memr) begin
                  o_sig_d.wdata = al_load;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d       = ST_DONE;
               req_d         = 1'b0;
               we_d          = 1'b0;
               be_d          = 4'b0000;
               fault_d       = 1'b1;
               o_sig_d       = cap_q;
               o_sig_d.wback = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            stall   = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         cap_q      <= '0;
         o_sig_q    <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= 4'b0000;
         redirect_q <= 1'b0;
         target_q   <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cap_q      <= cap_d;
         o_sig_q    <= o_sig_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         redirect_q <= redirect_d;
         target_q   <= target_d;
         fault_q    <= fault_d;
      end
   end

   assign o_signals  = o_sig_q;
   assign o_stall    = stall;
   assign o_redirect = redirect_q;
   assign o_target   = target_q;
   assign o_fault    = fault_q;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_be    = be_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
   import Common::*;

   logic        clk = 1'b0;
   logic        rst;
   Signals      i_signals;
   Signals      o_signals;
   logic        o_stall, o_redirect, o_fault;
   logic [31:0] o_target;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;

   int tests_run    = 0;
   int tests_failed = 0;

   mem_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .i_signals(i_signals), .o_signals(o_signals),
      .o_stall(o_stall), .o_redirect(o_redirect), .o_target(o_target),
      .o_fault(o_fault), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
   );

   always #5 clk = ~clk;

   function automatic Signals mk_op(input logic memr, input logic memw, input MemType mt,
                                    input logic [31:0] wdata, input logic [31:0] reg2,
                                    input Cond c, input Flags f, input logic [31:0] branch);
      Signals s;
      s        = '0;
      s.valid  = 1'b1;
      s.pc     = 32'h40;
      s.reg2   = reg2;
      s.wback  = ~memw;
      s.wreg   = 5'd7;
      s.wdata  = wdata;
      s.branch = branch;
      s.flags  = f;
      s.cond   = c;
      s.memr   = memr;
      s.memw   = memw;
      s.memt   = mt;
      return s;
   endfunction

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_signals = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      @(negedge clk);
      tests_run++;
      if (o_signals.valid !== 1'b0 || o_signals.wback !== 1'b0 || o_signals.memr !== 1'b0 ||
          o_signals.memw !== 1'b0 || o_signals.cond !== C_NEVER) begin
         tests_failed++; $display("FAIL reset_osig: got v=%b wb=%b r=%b w=%b c=%0d, need all 0",
            o_signals.valid, o_signals.wback, o_signals.memr, o_signals.memw, o_signals.cond);
      end
      tests_run++;
      if ({o_stall, o_redirect, o_fault, dmem_req, dmem_we, dmem_be} !== 9'd0) begin
         tests_failed++; $display("FAIL reset_ctl: got %b, need 0",
            {o_stall, o_redirect, o_fault, dmem_req, dmem_we, dmem_be});
      end
      step(); rst = 1'b0;
      $display("[TB] reset");
   endtask

   task automatic test_alu();
      step();
      i_signals = mk_op(1'b0, 1'b0, MT_WORD, 32'h1234, 32'h0, C_ALWAYS, '{zero:1'b0, carry:1'b0}, 32'h400);
      @(negedge clk);
      tests_run++;
      if (o_stall !== 1'b0) begin
         tests_failed++; $display("FAIL alu_stall: got %b need 0", o_stall);
      end
      step(); i_signals = '0;
      @(negedge clk);
      tests_run++;
      if (o_signals.valid !== 1'b1 || o_signals.wdata !== 32'h1234 || o_signals.wback !== 1'b1) begin
         tests_failed++; $display("FAIL alu_pass: got v=%b wd=%h wb=%b need 1/00001234/1",
            o_signals.valid, o_signals.wdata, o_signals.wback);
      end
      tests_run++;
      if (dmem_req !== 1'b0) begin
         tests_failed++; $display("FAIL alu_noreq: got %b need 0", dmem_req);
      end
      tests_run++;
      if (o_redirect !== 1'b1 || o_target !== 32'h400) begin
         tests_failed++; $display("FAIL alu_redirect: got %b/%h need 1/00000400", o_redirect, o_target);
      end
      @(negedge clk);
      tests_run++;
      if (o_redirect !== 1'b0 || o_signals.valid !== 1'b0) begin
         tests_failed++; $display("FAIL alu_pulse: got redir=%b v=%b need 0/0", o_redirect, o_signals.valid);
      end
      $display("[TB] alu passthrough wdata=00001234");
   endtask

   task automatic test_cond();
      Cond  cs [6] = '{C_NEVER, C_EQ, C_NE, C_LT, C_GE, C_EQ};
      Flags fs [6] = '{'{1'b1, 1'b1}, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b0, 1'b1}, '{1'b0, 1'b1}, '{1'b0, 1'b0}};
      logic ex [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int k = 0; k < 6; k++) begin
         step();
         i_signals = mk_op(1'b0, 1'b0, MT_WORD, 32'h0, 32'h0, cs[k], fs[k], 32'h800 + 32'(k));
         step(); i_signals = '0;
         @(negedge clk);
         tests_run++;
         if (o_redirect !== ex[k]) begin
            tests_failed++; $display("FAIL cond_%0d: got redirect=%b need %b", k, o_redirect, ex[k]);
         end
         $display("[TB] cond case %0d redirect expected %b", k, ex[k]);
      end
      // Invalid op must not redirect even with an always-taken condition.
      step();
      i_signals = mk_op(1'b0, 1'b0, MT_WORD, 32'h0, 32'h0, C_ALWAYS, '{1'b0, 1'b0}, 32'h900);
      i_signals.valid = 1'b0;
      step(); i_signals = '0;
      @(negedge clk);
      tests_run++;
      if (o_redirect !== 1'b0 || o_signals.valid !== 1'b0) begin
         tests_failed++; $display("FAIL cond_invalid: got redir=%b v=%b need 0/0", o_redirect, o_signals.valid);
      end
   endtask

   task automatic test_load_byte();
      step();
      i_signals = mk_op(1'b1, 1'b0, MT_BYTE, 32'h103, 32'h0, C_NEVER, '{1'b0, 1'b0}, 32'h0);
      @(negedge clk);
      tests_run++;
      if (o_stall !== 1'b1 || dmem_req !== 1'b0) begin
         tests_failed++; $display("FAIL lb_capture: got stall=%b req=%b need 1/0", o_stall, dmem_req);
      end
      step(); i_signals = '0;
      @(negedge clk);
      tests_run++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || dmem_be !== 4'b1000 || o_stall !== 1'b1) begin
         tests_failed++; $display("FAIL lb_req: got req=%b we=%b a=%h be=%b st=%b need 1/0/00000100/1000/1",
            dmem_req, dmem_we, dmem_addr, dmem_be, o_stall);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (dmem_req !== 1'b1 || o_stall !== 1'b1 || o_signals.valid !== 1'b0) begin
         tests_failed++; $display("FAIL lb_wait: got req=%b st=%b v=%b need 1/1/0", dmem_req, o_stall, o_signals.valid);
      end
      step(); dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FFFF;
      @(negedge clk);
      tests_run++;
      if (dmem_req !== 1'b1 || o_stall !== 1'b1 || o_signals.valid !== 1'b0) begin
         tests_failed++; $display("FAIL lb_ack: got req=%b st=%b v=%b need 1/1/0", dmem_req, o_stall, o_signals.valid);
      end
      step(); dmem_ack = 1'b0; dmem_rdata = '0;
      @(negedge clk);
      tests_run++;
      if (o_signals.valid !== 1'b1 || o_signals.wdata !== 32'hFFFF_FF80 || o_signals.wback !== 1'b1 ||
          dmem_req !== 1'b0 || o_stall !== 1'b1 || o_fault !== 1'b0) begin
         tests_failed++; $display("FAIL lb_done: got v=%b wd=%h wb=%b req=%b st=%b f=%b need 1/ffffff80/1/0/1/0",
            o_signals.valid, o_signals.wdata, o_signals.wback, dmem_req, o_stall, o_fault);
      end
      @(negedge clk);
      tests_run++;
      if (o_stall !== 1'b0 || o_signals.valid !== 1'b0) begin
         tests_failed++; $display("FAIL lb_idle: got st=%b v=%b need 0/0", o_stall, o_signals.valid);
      end
      $display("[TB] load byte 0x103 -> ffffff80");
   endtask

   task automatic test_store_half();
      step();
      i_signals = mk_op(1'b0, 1'b1, MT_HALF, 32'h102, 32'h0000_ABCD, C_NEVER, '{1'b0, 1'b0}, 32'h0);
      step(); i_signals = '0; dmem_ack = 1'b1;
      @(negedge clk);
      tests_run++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD ||
          dmem_addr !== 32'h100) begin
         tests_failed++; $display("FAIL sh_req: got req=%b we=%b be=%b wd=%h a=%h need 1/1/1100/abcdabcd/00000100",
            dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr);
      end
      step(); dmem_ack = 1'b0;
      @(negedge clk);
      tests_run++;
      if (dmem_req !== 1'b0 || o_signals.valid !== 1'b1 || o_signals.memw !== 1'b1 || o_fault !== 1'b0) begin
         tests_failed++; $display("FAIL sh_done: got req=%b v=%b mw=%b f=%b need 0/1/1/0",
            dmem_req, o_signals.valid, o_signals.memw, o_fault);
      end
      $display("[TB] store half 0x102 <- abcd");
   endtask

   task automatic test_load_variety();
      MemType      mts [4] = '{MT_BYTEU, MT_HALF, MT_HALFU, MT_WORD};
      logic [31:0] ads [4] = '{32'h201, 32'h300, 32'h402, 32'h500};
      logic [31:0] rds [4] = '{32'h0000_9A00, 32'h1234_F00F, 32'h8001_1234, 32'hDEAD_BEEF};
      logic [31:0] exs [4] = '{32'h0000_009A, 32'hFFFF_F00F, 32'h0000_8001, 32'hDEAD_BEEF};
      logic [3:0]  bes [4] = '{4'b0010, 4'b0011, 4'b1100, 4'b1111};
      for (int k = 0; k < 4; k++) begin
         step();
         i_signals = mk_op(1'b1, 1'b0, mts[k], ads[k], 32'h0, C_NEVER, '{1'b0, 1'b0}, 32'h0);
         step(); i_signals = '0; dmem_ack = 1'b1; dmem_rdata = rds[k];
         @(negedge clk);
         tests_run++;
         if (dmem_be !== bes[k]) begin
            tests_failed++; $display("FAIL ld_be_%0d: got %b need %b", k, dmem_be, bes[k]);
         end
         step(); dmem_ack = 1'b0; dmem_rdata = '0;
         @(negedge clk);
         tests_run++;
         if (o_signals.valid !== 1'b1 || o_signals.wdata !== exs[k]) begin
            tests_failed++; $display("FAIL ld_data_%0d: got v=%b wd=%h need 1/%h", k, o_signals.valid, o_signals.wdata, exs[k]);
         end
         $display("[TB] load type %0d addr %h -> %h", k, ads[k], exs[k]);
      end
   endtask

   task automatic test_misaligned();
      MemType      mts [2] = '{MT_WORD, MT_HALF};
      logic [31:0] ads [2] = '{32'h101, 32'h103};
      logic        wrs [2] = '{1'b0, 1'b1};
      for (int k = 0; k < 2; k++) begin
         step();
         i_signals = mk_op(~wrs[k], wrs[k], mts[k], ads[k], 32'h55, C_NEVER, '{1'b0, 1'b0}, 32'h0);
         step(); i_signals = '0;
         @(negedge clk);
         tests_run++;
         if (dmem_req !== 1'b0 || o_fault !== 1'b1 || o_signals.valid !== 1'b1 || o_signals.wback !== 1'b0) begin
            tests_failed++; $display("FAIL mis_%0d: got req=%b f=%b v=%b wb=%b need 0/1/1/0",
               k, dmem_req, o_fault, o_signals.valid, o_signals.wback);
         end
         @(negedge clk);
         tests_run++;
         if (o_fault !== 1'b0 || dmem_req !== 1'b0 || o_stall !== 1'b0) begin
            tests_failed++; $display("FAIL mis_after_%0d: got f=%b req=%b st=%b need 0/0/0", k, o_fault, dmem_req, o_stall);
         end
         $display("[TB] misaligned access %0d at %h faulted", k, ads[k]);
      end
   endtask

   task automatic test_timeout();
      for (int pass = 0; pass < 2; pass++) begin
         step();
         i_signals = mk_op(1'b1, 1'b0, MT_WORD, 32'h200, 32'h0, C_NEVER, '{1'b0, 1'b0}, 32'h0);
         for (int c = 0; c < 4; c++) begin
            step(); i_signals = '0;
            if (pass == 1 && c == 3) begin
               dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
            end
            @(negedge clk);
            tests_run++;
            if (dmem_req !== 1'b1) begin
               tests_failed++; $display("FAIL to_req_%0d_%0d: got %b need 1", pass, c, dmem_req);
            end
         end
         step(); dmem_ack = 1'b0; dmem_rdata = '0;
         @(negedge clk);
         tests_run++;
         if (pass == 0 && (dmem_req !== 1'b0 || o_fault !== 1'b1 || o_signals.valid !== 1'b1 || o_signals.wback !== 1'b0)) begin
            tests_failed++; $display("FAIL to_fault: got req=%b f=%b v=%b wb=%b need 0/1/1/0",
               dmem_req, o_fault, o_signals.valid, o_signals.wback);
         end
         if (pass == 1 && (dmem_req !== 1'b0 || o_fault !== 1'b0 || o_signals.valid !== 1'b1 ||
                           o_signals.wback !== 1'b1 || o_signals.wdata !== 32'h0BAD_F00D)) begin
            tests_failed++; $display("FAIL to_ackwins: got req=%b f=%b v=%b wb=%b wd=%h need 0/0/1/1/0badf00d",
               dmem_req, o_fault, o_signals.valid, o_signals.wback, o_signals.wdata);
         end
         @(negedge clk);
         tests_run++;
         if (o_fault !== 1'b0 || o_stall !== 1'b0) begin
            tests_failed++; $display("FAIL to_idle_%0d: got f=%b st=%b need 0/0", pass, o_fault, o_stall);
         end
         $display("[TB] timeout pass %0d (%s)", pass, (pass == 0) ? "no ack" : "ack on last cycle");
      end
   endtask

   task automatic test_stray_ack();
      step(); dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      step(); dmem_ack = 1'b0; dmem_rdata = '0;
      @(negedge clk);
      tests_run++;
      if (o_signals.valid !== 1'b0 || o_fault !== 1'b0 || dmem_req !== 1'b0 || o_stall !== 1'b0) begin
         tests_failed++; $display("FAIL stray_ack: got v=%b f=%b req=%b st=%b need 0/0/0/0",
            o_signals.valid, o_fault, dmem_req, o_stall);
      end
      $display("[TB] stray ack ignored");
   endtask

   task automatic test_reset_mid_access();
      step();
      i_signals = mk_op(1'b1, 1'b0, MT_WORD, 32'h600, 32'h0, C_NEVER, '{1'b0, 1'b0}, 32'h0);
      step(); i_signals = '0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (dmem_req !== 1'b0 || o_stall !== 1'b0) begin
         tests_failed++; $display("FAIL rst_mid: got req=%b st=%b need 0/0", dmem_req, o_stall);
      end
      step(); rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
      @(negedge clk);
      step(); dmem_ack = 1'b0; dmem_rdata = '0;
      @(negedge clk);
      tests_run++;
      if (o_signals.valid !== 1'b0 || o_fault !== 1'b0 || dmem_req !== 1'b0 || o_stall !== 1'b0) begin
         tests_failed++; $display("FAIL rst_late_ack: got v=%b f=%b req=%b st=%b need 0/0/0/0",
            o_signals.valid, o_fault, dmem_req, o_stall);
      end
      // Stage must be back in Idle: an ALU op passes straight through.
      step();
      i_signals = mk_op(1'b0, 1'b0, MT_WORD, 32'h5A5A, 32'h0, C_NEVER, '{1'b0, 1'b0}, 32'h0);
      step(); i_signals = '0;
      @(negedge clk);
      tests_run++;
      if (o_signals.valid !== 1'b1 || o_signals.wdata !== 32'h5A5A) begin
         tests_failed++; $display("FAIL rst_idle: got v=%b wd=%h need 1/00005a5a", o_signals.valid, o_signals.wdata);
      end
      $display("[TB] reset mid-access abandoned");
   endtask

   initial begin
      test_reset();
      test_alu();
      test_cond();
      test_load_byte();
      test_store_half();
      test_load_variety();
      test_misaligned();
      test_timeout();
      test_stray_ack();
      test_reset_mid_access();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
